wb_snap_bram: RTL and testbench

- Wishbone-readable multi-channel snapshot buffer.
- Captures N_CHANNELS x CHANNEL_WIDTH user samples into block RAM after an arm/trigger sequence, then exposes them as 32-bit words on the Wishbone bus.
- Successor to the plain user-write/WB-read BRAM: adds parametric channel count and width, a capture state machine, a programmable length, and control/status registers.
- Single clock domain: the user sample port runs on wb_clk_i.

---
 rtl/wb_snap_pkg.sv | 30 +++
 rtl/wb_snap_sdp_ram.sv | 25 ++
 rtl/wb_snap_bram.sv | 240 ++++++++++++++++++++++++
 tb/tb_wb_snap_bram.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_snap_pkg.sv
// Shared definitions for the wb_snap_bram snapshot buffer: register map,
// CTRL/STATUS bit positions, capture FSM states and bus latency.
package wb_snap_pkg;

    localparam int unsigned REG_CTRL      = 0;
    localparam int unsigned REG_STATUS    = 1;
    localparam int unsigned REG_LENGTH    = 2;
    localparam int unsigned REG_PRETRIG   = 3;
    localparam int unsigned REG_TRIG_ADDR = 4;

    localparam int unsigned CTRL_ARM     = 0;
    localparam int unsigned CTRL_SW_TRIG = 1;
    localparam int unsigned CTRL_ABORT   = 2;

    localparam int unsigned STAT_ARMED     = 0;
    localparam int unsigned STAT_CAPTURING = 1;
    localparam int unsigned STAT_DONE      = 2;
    localparam int unsigned STAT_COUNT_LSB = 16;

    // Cycles from acceptance to ack; must be at least 2.
    localparam int unsigned WB_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } snap_state_t;

endpackage

// File: rtl/wb_snap_sdp_ram.sv
// Simple dual-port sample RAM: one write port, one registered read-first
// read port, single clock. Contents are not reset.
module wb_snap_sdp_ram #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_BITS)-1];

    // Both updates are non-blocking, so a same-address read sees old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/wb_snap_bram.sv
// Wishbone-readable multi-channel snapshot buffer with arm/trigger capture FSM.
// Optional pre-trigger circular capture is enabled by defining WB_SNAP_PRETRIG_EN.
module wb_snap_bram
    import wb_snap_pkg::*;
#(
    parameter int unsigned N_CHANNELS    = 4,
    parameter int unsigned CHANNEL_WIDTH = 32,
    parameter int unsigned ADDR_BITS     = 10
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_i,
    input  logic                                wb_cyc_i,
    input  logic                                wb_stb_i,
    input  logic                                wb_we_i,
    input  logic [3:0]                          wb_sel_i,
    input  logic [31:0]                         wb_adr_i,
    input  logic [31:0]                         wb_dat_i,
    output logic [31:0]                         wb_dat_o,
    output logic                                wb_ack_o,
    output logic                                wb_err_o,
    input  logic [N_CHANNELS*CHANNEL_WIDTH-1:0] user_din,
    input  logic                                user_valid,
    input  logic                                user_trig,
    output logic                                capturing,
    output logic                                capture_done
);

    localparam int unsigned SAMPLE_WIDTH = N_CHANNELS * CHANNEL_WIDTH;
    localparam int unsigned WPS          = SAMPLE_WIDTH / 32;
    localparam int unsigned LWPS         = $clog2(WPS);
    localparam int unsigned WORD_BITS    = ADDR_BITS + LWPS;
    localparam int unsigned SEL_BIT      = WORD_BITS + 2;
    localparam int unsigned SLICE_W      = (LWPS > 0) ? LWPS : 1;
    localparam int unsigned LEN_W        = ADDR_BITS + 1;
    localparam logic [LEN_W-1:0] DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};

`ifdef WB_SNAP_PRETRIG_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif

    snap_state_t state_q, state_d;

    logic [WB_LATENCY-1:0] pipe_q;
    logic                  accept;
    logic                  lat_buf, lat_we, lat_sel_full;
    logic [WORD_BITS-1:0]  lat_word;
    logic [SLICE_W-1:0]    lat_slice, acc_slice;
    logic [LEN_W-1:0]      lat_dat;

    logic [LEN_W-1:0]      length_q, pretrig_q, count_q, pre_cnt_q;
    logic [ADDR_BITS-1:0]  wr_ptr_q, trig_addr_q;
    logic [LEN_W-1:0]      eff_len, eff_pre, target;

    logic reg_wr, ctrl_wr, arm, sw_trig, abort, clear;
    logic pre_ok, trig_hit, trig_fire, count_inc, pre_inc, ram_we;

    logic [SAMPLE_WIDTH-1:0] ram_rdata;
    logic [31:0]             buf_rdata, reg_rdata;
    logic                    unused_bits;

    assign wb_err_o     = 1'b0;
    assign capturing    = (state_q == CAPTURE);
    assign capture_done = (state_q == DONE);
    assign unused_bits  = ^{wb_adr_i[31:SEL_BIT+1], wb_adr_i[1:0], wb_dat_i[31:LEN_W]};

    generate
        if (LWPS == 0) begin : g_one_slice
            assign acc_slice = '0;
        end else begin : g_multi_slice
            assign acc_slice = wb_adr_i[LWPS+1:2];
        end
    endgenerate

    // Bus handshake: accept once, then ack WB_LATENCY cycles later.
    assign accept   = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~(|pipe_q);
    assign wb_ack_o = pipe_q[WB_LATENCY-1];

    assign reg_wr  = wb_ack_o & lat_we & lat_sel_full & ~lat_buf;
    assign ctrl_wr = reg_wr && (lat_word == WORD_BITS'(REG_CTRL));
    assign arm     = ctrl_wr & lat_dat[CTRL_ARM];
    assign sw_trig = ctrl_wr & lat_dat[CTRL_SW_TRIG];
    assign abort   = ctrl_wr & lat_dat[CTRL_ABORT];
    assign clear   = abort | (arm & ((state_q == IDLE) | (state_q == DONE)));

    always_comb begin
        eff_len = length_q;
        if ((length_q == '0) || (length_q > DEPTH)) begin
            eff_len = DEPTH;
        end
        eff_pre = '0;
        if (PRE_EN) begin
            eff_pre = (pretrig_q >= eff_len) ? (eff_len - LEN_W'(1)) : pretrig_q;
        end
        target = eff_len - eff_pre;
    end

    assign pre_ok   = (pre_cnt_q >= eff_pre);
    assign trig_hit = ((user_valid & user_trig) | sw_trig) & pre_ok;

    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        trig_fire = 1'b0;
        count_inc = 1'b0;
        pre_inc   = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) state_d = ARMED;
                end
                ARMED: begin
                    if (trig_hit) begin
                        trig_fire = 1'b1;
                        state_d   = CAPTURE;
                        if (user_valid) begin
                            ram_we    = 1'b1;
                            count_inc = 1'b1;
                            if (target == LEN_W'(1)) state_d = DONE;
                        end
                    end else if (PRE_EN && user_valid) begin
                        ram_we  = 1'b1;
                        pre_inc = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (user_valid) begin
                        ram_we    = 1'b1;
                        count_inc = 1'b1;
                        if ((count_q + LEN_W'(1)) == target) state_d = DONE;
                    end
                end
                DONE: begin
                    if (arm) state_d = ARMED;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pre_cnt_q   <= '0;
            trig_addr_q <= '0;
            length_q    <= '0;
            pretrig_q   <= '0;
        end else begin
            if (clear) begin
                wr_ptr_q  <= '0;
                count_q   <= '0;
                pre_cnt_q <= '0;
            end else begin
                if (ram_we)    wr_ptr_q <= wr_ptr_q + ADDR_BITS'(1);
                if (count_inc) count_q  <= count_q + LEN_W'(1);
                if (pre_inc && (pre_cnt_q != DEPTH)) pre_cnt_q <= pre_cnt_q + LEN_W'(1);
                if (trig_fire) trig_addr_q <= wr_ptr_q;
            end
            if (reg_wr && (lat_word == WORD_BITS'(REG_LENGTH))) length_q <= lat_dat;
            if (PRE_EN && reg_wr && (lat_word == WORD_BITS'(REG_PRETRIG))) pretrig_q <= lat_dat;
        end
    end

    wb_snap_sdp_ram #(
        .WIDTH     (SAMPLE_WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (wb_clk_i),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (user_din),
        .raddr (wb_adr_i[SEL_BIT-1 -: ADDR_BITS]),
        .rdata (ram_rdata)
    );

    // Slice 0 is the most-significant 32 bits of the sample.
    always_comb begin
        buf_rdata = '0;
        for (int unsigned i = 0; i < WPS; i++) begin
            if (lat_slice == SLICE_W'(i)) buf_rdata = ram_rdata[SAMPLE_WIDTH-1-32*i -: 32];
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (lat_word == WORD_BITS'(REG_STATUS)) begin
            reg_rdata[STAT_ARMED]            = (state_q == ARMED);
            reg_rdata[STAT_CAPTURING]        = (state_q == CAPTURE);
            reg_rdata[STAT_DONE]             = (state_q == DONE);
            reg_rdata[STAT_COUNT_LSB +: 16]  = 16'(count_q);
        end else if (lat_word == WORD_BITS'(REG_LENGTH)) begin
            reg_rdata[LEN_W-1:0] = length_q;
        end else if (PRE_EN && (lat_word == WORD_BITS'(REG_PRETRIG))) begin
            reg_rdata[LEN_W-1:0] = pretrig_q;
        end else if (PRE_EN && (lat_word == WORD_BITS'(REG_TRIG_ADDR))) begin
            reg_rdata[ADDR_BITS-1:0] = trig_addr_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            pipe_q       <= '0;
            wb_dat_o     <= '0;
            lat_buf      <= 1'b0;
            lat_we       <= 1'b0;
            lat_sel_full <= 1'b0;
            lat_word     <= '0;
            lat_slice    <= '0;
            lat_dat      <= '0;
        end else begin
            pipe_q <= {pipe_q[WB_LATENCY-2:0], accept};
            if (accept) begin
                lat_buf      <= wb_adr_i[SEL_BIT];
                lat_we       <= wb_we_i;
                lat_sel_full <= (wb_sel_i == 4'hf);
                lat_word     <= wb_adr_i[SEL_BIT-1:2];
                lat_slice    <= acc_slice;
                lat_dat      <= wb_dat_i[LEN_W-1:0];
            end
            if (pipe_q[WB_LATENCY-2] && !lat_we) begin
                wb_dat_o <= lat_buf ? buf_rdata : reg_rdata;
            end else begin
                wb_dat_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_snap_bram.sv
// Directed self-checking bench for wb_snap_bram (default parameters).
// Pre-trigger scenario is compiled in when WB_SNAP_PRETRIG_EN is defined.
module tb_wb_snap_bram;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cyc, stb, we;
    logic [3:0]   sel;
    logic [31:0]  adr, dat_w;
    logic [31:0]  dat_r;
    logic         ack, err;
    logic [127:0] din;
    logic         valid, trig;
    logic         capturing, done;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] BUF      = 32'h0000_4000;
    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_LENGTH = 32'h8;
    localparam logic [31:0] A_PRE    = 32'hC;
    localparam logic [31:0] A_TADDR  = 32'h10;

    always #5 clk = ~clk;

    wb_snap_bram dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst_n),
        .wb_cyc_i     (cyc),
        .wb_stb_i     (stb),
        .wb_we_i      (we),
        .wb_sel_i     (sel),
        .wb_adr_i     (adr),
        .wb_dat_i     (dat_w),
        .wb_dat_o     (dat_r),
        .wb_ack_o     (ack),
        .wb_err_o     (err),
        .user_din     (din),
        .user_valid   (valid),
        .user_trig    (trig),
        .capturing    (capturing),
        .capture_done (done)
    );

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r, output int lat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        lat = 0; r = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = n;
                r = dat_r;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL wb_timeout adr=%h got no ack, required ack within 20 cycles", a);
        end
        @(posedge clk); #1;
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int lat;
        wb_xfer(1'b1, a, d, 4'hf, r, lat);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] r);
        int lat;
        wb_xfer(1'b0, a, 32'h0, 4'hf, r, lat);
    endtask

    task automatic user_cycle(input logic [127:0] d, input logic v, input logic t);
        din = d; valid = v; trig = t;
        @(posedge clk); #1;
        valid = 1'b0; trig = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst_n = 1'b0; cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = '0; dat_w = '0;
        din = '0; valid = 0; trig = 0;
        #1;
        checks++;
        if ({ack, dat_r, capturing, done, err} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {ack, dat_r, capturing, done, err});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_status got %h required 0", r); end
        wb_rd(A_LENGTH, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_length got %h required 0", r); end
    endtask

    task automatic test_basic();
        logic [31:0] r;
        logic [31:0] exp_w [8];
        int lat;
        exp_w = '{32'h11001101, 32'h22002202, 32'h33003303, 32'h44004404,
                  32'h55005505, 32'h66006606, 32'h77007707, 32'h88008808};
        wb_wr(A_LENGTH, 32'd2);
        wb_wr(A_CTRL, 32'h1);
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL basic_armed got %h required 1", r); end
        user_cycle({exp_w[0], exp_w[1], exp_w[2], exp_w[3]}, 1'b1, 1'b1);
        user_cycle({exp_w[4], exp_w[5], exp_w[6], exp_w[7]}, 1'b1, 1'b0);
        checks++;
        if ({capturing, done} !== 2'b01) begin
            errors++; $display("FAIL basic_done_pins got %b required 01", {capturing, done});
        end
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h0002_0004) begin errors++; $display("FAIL basic_status got %h required 00020004", r); end
        for (int w = 0; w < 8; w++) begin
            wb_xfer(1'b0, BUF + 32'(4 * w), 32'h0, 4'hf, r, lat);
            checks++;
            if (r !== exp_w[w]) begin errors++; $display("FAIL basic_word%0d got %h required %h", w, r, exp_w[w]); end
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL basic_latency%0d got %0d required 2", w, lat); end
        end
        checks++;
        if ({ack, dat_r} !== 33'h0) begin
            errors++; $display("FAIL ack_one_cycle got ack=%b dat=%h required 0 0", ack, dat_r);
        end
    endtask

    task automatic test_full_length();
        logic [31:0] r;
        wb_wr(A_LENGTH, 32'd0);
        wb_wr(A_CTRL, 32'h1);
        for (int i = 0; i < 1100; i++) begin
            user_cycle({4{32'(i)}}, 1'b1, (i == 0));
            if (i == 1022) begin
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL full_early_done got %b required 0", done); end
            end
        end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL full_done got %b required 1", done); end
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h0400_0004) begin errors++; $display("FAIL full_status got %h required 04000004", r); end
        wb_rd(BUF + 32'h3FF0, r);
        checks++;
        if (r !== 32'h3FF) begin errors++; $display("FAIL full_last_ch0 got %h required 3ff", r); end
        wb_rd(BUF + 32'h3FFC, r);
        checks++;
        if (r !== 32'h3FF) begin errors++; $display("FAIL full_last_ch3 got %h required 3ff", r); end
        wb_rd(BUF, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL full_no_wrap got %h required 0", r); end
    endtask

    task automatic test_valid_gap();
        logic [31:0] r;
        wb_wr(A_LENGTH, 32'd2);
        wb_wr(A_CTRL, 32'h1);
        wb_wr(A_CTRL, 32'h2);
        checks++;
        if (capturing !== 1'b1) begin errors++; $display("FAIL gap_capturing got %b required 1", capturing); end
        user_cycle({4{32'hA1}}, 1'b1, 1'b0);
        user_cycle({4{32'hB2}}, 1'b0, 1'b0);
        user_cycle({4{32'hC3}}, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL gap_paused got %b required 0", done); end
        user_cycle({4{32'hD4}}, 1'b1, 1'b0);
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h0002_0004) begin errors++; $display("FAIL gap_status got %h required 00020004", r); end
        wb_rd(BUF + 32'h0, r);
        checks++;
        if (r !== 32'hA1) begin errors++; $display("FAIL gap_sample0 got %h required a1", r); end
        wb_rd(BUF + 32'h10, r);
        checks++;
        if (r !== 32'hD4) begin errors++; $display("FAIL gap_sample1 got %h required d4", r); end
    endtask

    task automatic test_abort();
        logic [31:0] r;
        wb_wr(A_CTRL, 32'h1);
        wb_wr(A_CTRL, 32'h2);
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL abort_pre got %h required 2", r); end
        wb_wr(A_CTRL, 32'h5);
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL abort_idle got %h required 0", r); end
        wb_wr(A_CTRL, 32'h1);
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL abort_rearm got %h required 1", r); end
    endtask

    task automatic test_regs();
        logic [31:0] r;
        int lat;
        wb_wr(A_LENGTH, 32'h5);
        wb_xfer(1'b1, A_LENGTH, 32'h9, 4'h3, r, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL regs_partial_ack got %0d required 2", lat); end
        wb_rd(A_LENGTH, r);
        checks++;
        if (r !== 32'h5) begin errors++; $display("FAIL regs_partial_ignored got %h required 5", r); end
        wb_wr(A_LENGTH, 32'hFFFF_FFFF);
        wb_rd(A_LENGTH, r);
        checks++;
        if (r !== 32'h7FF) begin errors++; $display("FAIL regs_length_width got %h required 7ff", r); end
        wb_rd(A_CTRL, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL regs_ctrl_read got %h required 0", r); end
        wb_wr(32'h1C, 32'h1234);
        wb_rd(32'h1C, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL regs_unmapped got %h required 0", r); end
`ifndef WB_SNAP_PRETRIG_EN
        wb_wr(A_PRE, 32'h3);
        wb_rd(A_PRE, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL regs_pretrig_absent got %h required 0", r); end
        wb_rd(A_TADDR, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL regs_trigaddr_absent got %h required 0", r); end
`endif
    endtask

`ifdef WB_SNAP_PRETRIG_EN
    task automatic test_pretrig();
        logic [31:0] r;
        wb_wr(A_CTRL, 32'h4);
        wb_wr(A_LENGTH, 32'd8);
        wb_wr(A_PRE, 32'd3);
        wb_wr(A_CTRL, 32'h1);
        for (int i = 0; i < 21; i++) begin
            user_cycle({4{32'h100 + 32'(i)}}, 1'b1, (i == 1) || (i == 10));
        end
        wb_rd(A_TADDR, r);
        checks++;
        if (r !== 32'd10) begin errors++; $display("FAIL pre_trig_addr got %h required a", r); end
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h0005_0004) begin errors++; $display("FAIL pre_status got %h required 00050004", r); end
        for (int s = 7; s <= 14; s++) begin
            wb_rd(BUF + 32'(16 * s), r);
            checks++;
            if (r !== 32'h100 + 32'(s)) begin
                errors++; $display("FAIL pre_sample%0d got %h required %h", s, r, 32'h100 + 32'(s));
            end
        end
        wb_rd(BUF + 32'(16 * 15), r);
        checks++;
        if (r !== 32'd15) begin errors++; $display("FAIL pre_stop got %h required f", r); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] r;
        wb_wr(A_CTRL, 32'h4);
        wb_wr(A_LENGTH, 32'd5);
        wb_wr(A_CTRL, 32'h1);
        wb_wr(A_CTRL, 32'h2);
        user_cycle({4{32'hEE}}, 1'b1, 1'b0);
        checks++;
        if (capturing !== 1'b1) begin errors++; $display("FAIL mid_capturing got %b required 1", capturing); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({capturing, done, ack, dat_r} !== 35'h0) begin
            errors++; $display("FAIL mid_reset_outputs got %h required 0", {capturing, done, ack, dat_r});
        end
        @(posedge clk); #1 rst_n = 1'b1;
        wb_rd(A_LENGTH, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL mid_length got %h required 0", r); end
        wb_rd(A_STATUS, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL mid_status got %h required 0", r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_length();
        test_valid_gap();
        test_abort();
        test_regs();
`ifdef WB_SNAP_PRETRIG_EN
        test_pretrig();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
